banco_escalonador: RTL

Write-port scheduler and hazard scoreboard for `bancoRegistrador`, the 16 x 32-bit register bank with two combinational read ports and one write port.
- Arbitrates the single write port between two writeback requesters: requester 0 is the ALU result, requester 1 is the memory load.
- Tracks pending destination registers and flags read-after-write hazards to the issue logic.
- Drives the bank's address, data and enable pins directly, so the bank has no other write master.

---
 rtl/banco_escalonador_if.sv | 23 ++
 rtl/banco_escalonador.sv | 69 ++++++
 2 files changed

// File: rtl/banco_escalonador_if.sv
// banco_escalonador_if: writeback, reservation, issue-read and bank pins of the write-port scheduler
interface banco_escalonador_if;
  logic        r0_valid, r1_valid, r0_ready, r1_ready;
  logic        reserve_en, rd_use1, rd_use2, rd_stall, bank_wr_en;
  logic [3:0]  r0_addr, r1_addr, reserve_addr, rd_addr1, rd_addr2;
  logic [3:0]  bank_rd1, bank_rd2, bank_wr_addr;
  logic [31:0] r0_data, r1_data, rd_data1, rd_data2;
  logic [31:0] bank_out1, bank_out2, bank_wr_data;
  modport slave (
    input  r0_valid, r0_addr, r0_data, r1_valid, r1_addr, r1_data,
           reserve_en, reserve_addr, rd_addr1, rd_addr2, rd_use1, rd_use2,
           bank_out1, bank_out2,
    output r0_ready, r1_ready, rd_data1, rd_data2, rd_stall,
           bank_rd1, bank_rd2, bank_wr_addr, bank_wr_data, bank_wr_en
  );
  modport master (
    output r0_valid, r0_addr, r0_data, r1_valid, r1_addr, r1_data,
           reserve_en, reserve_addr, rd_addr1, rd_addr2, rd_use1, rd_use2,
           bank_out1, bank_out2,
    input  r0_ready, r1_ready, rd_data1, rd_data2, rd_stall,
           bank_rd1, bank_rd2, bank_wr_addr, bank_wr_data, bank_wr_en
  );
endinterface

// File: rtl/banco_escalonador.sv
// banco_escalonador: write-port arbiter and RAW scoreboard for bancoRegistrador; define BANCO_BYPASS_EN to forward the in-flight write to reads
module banco_escalonador (
  input logic clk,
  input logic rst,
  banco_escalonador_if.slave bus
);
  logic [15:0] busy;
  logic        prio;
  logic        g0, g1;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        fwd1, fwd2;
  // round-robin grant: a lone requester wins, contention goes to prio
  always_comb begin
    g0 = ~rst & bus.r0_valid & (~bus.r1_valid | ~prio);
    g1 = ~rst & bus.r1_valid & (~bus.r0_valid | prio);
  end
  // prio flips to the loser only on contended cycles
  always_ff @(posedge clk) begin
    if (rst) prio <= 1'b0;
    else if (bus.r0_valid & bus.r1_valid) prio <= ~prio;
  end
  // single-cycle write stage driving the bank write port
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= 4'd0;
      wr_data <= 32'd0;
    end else begin
      wr_en <= g0 | g1;
      if (g0 | g1) begin
        wr_addr <= g1 ? bus.r1_addr : bus.r0_addr;
        wr_data <= g1 ? bus.r1_data : bus.r0_data;
      end
    end
  end
  // scoreboard: the write clears its bit, a same-edge reserve re-sets it
  always_ff @(posedge clk) begin
    if (rst) busy <= 16'd0;
    else busy <= (busy & ~({15'd0, wr_en} << wr_addr)) | ({15'd0, bus.reserve_en} << bus.reserve_addr);
  end
`ifdef BANCO_BYPASS_EN
  // forward the write-stage value to a matching source
  always_comb begin
    fwd1 = wr_en & (wr_addr == bus.rd_addr1);
    fwd2 = wr_en & (wr_addr == bus.rd_addr2);
  end
`else
  // no bypass: reads always see the bank
  always_comb begin
    fwd1 = 1'b0;
    fwd2 = 1'b0;
  end
`endif
  // combinational read path, hazard and port outputs
  always_comb begin
    bus.r0_ready     = g0;
    bus.r1_ready     = g1;
    bus.bank_rd1     = bus.rd_addr1;
    bus.bank_rd2     = bus.rd_addr2;
    bus.bank_wr_en   = wr_en;
    bus.bank_wr_addr = wr_addr;
    bus.bank_wr_data = wr_data;
    bus.rd_data1     = fwd1 ? wr_data : bus.bank_out1;
    bus.rd_data2     = fwd2 ? wr_data : bus.bank_out2;
    bus.rd_stall     = (bus.rd_use1 & busy[bus.rd_addr1] & ~fwd1) | (bus.rd_use2 & busy[bus.rd_addr2] & ~fwd2);
  end
endmodule
